// File: rtl/spi_key_loader.sv
// Framed serial key loader: assembles NUM_WORDS x WORD_W bits from a chip-select
// delimited stream into a staging store and commits them atomically to an active store.
module spi_key_loader #(
  parameter int unsigned WORD_W    = 48,
  parameter int unsigned NUM_WORDS = 16,
  parameter int unsigned LSB_FIRST = 0,
  parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
  input  logic              spi_clk,
  input  logic              n_reset,
  input  logic              spi_cs_n,
  input  logic              spi_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_word,
  output logic              key_valid,
  output logic              load_done,
  output logic              busy,
  output logic              frame_error
);

  localparam int unsigned CNT_W = $clog2(WORD_W);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] LastWord = IDX_W'(NUM_WORDS - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              key_valid_q, key_valid_d;
  logic              load_done_q, load_done_d;
  logic              frame_error_q, frame_error_d;

  logic [WORD_W-1:0] staging_q [NUM_WORDS];
  logic [WORD_W-1:0] active_q  [NUM_WORDS];

  logic [WORD_W-1:0] asm_base;
  logic [WORD_W-1:0] asm_next;
  logic              word_wr;
  logic              commit;

  // A new frame always assembles from zero, whatever the assembly register holds.
  always_comb begin
    asm_base = (state_q == StShift) ? asm_q : '0;
    if (LSB_FIRST != 0) begin
      asm_next = {spi_data, asm_base[WORD_W-1:1]};
    end else begin
      asm_next = {asm_base[WORD_W-2:0], spi_data};
    end
  end

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    asm_d         = asm_q;
    key_valid_d   = key_valid_q;
    load_done_d   = 1'b0;
    frame_error_d = frame_error_q;
    word_wr       = 1'b0;
    commit        = 1'b0;

    case (state_q)
      StIdle: begin
        if (!spi_cs_n) begin
          asm_d         = asm_next;
          bit_cnt_d     = CNT_W'(1);
          word_idx_d    = '0;
          frame_error_d = 1'b0;
          state_d       = StShift;
        end
      end

      StShift: begin
        if (spi_cs_n) begin
          // Abort: active store and key_valid are left untouched.
          frame_error_d = 1'b1;
          bit_cnt_d     = '0;
          word_idx_d    = '0;
          asm_d         = '0;
          state_d       = StIdle;
        end else if (bit_cnt_q == LastBit) begin
          word_wr   = 1'b1;
          bit_cnt_d = '0;
          asm_d     = '0;
          if (word_idx_q == LastWord) begin
            commit      = 1'b1;
            key_valid_d = 1'b1;
            load_done_d = 1'b1;
            word_idx_d  = '0;
            state_d     = StDone;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
          end
        end else begin
          asm_d     = asm_next;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end

      StDone: begin
        if (!spi_cs_n) begin
          frame_error_d = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      word_idx_q    <= '0;
      asm_q         <= '0;
      key_valid_q   <= 1'b0;
      load_done_q   <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      asm_q         <= asm_d;
      key_valid_q   <= key_valid_d;
      load_done_q   <= load_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  // The last word bypasses staging so the whole key lands in active on one edge.
  always_ff @(posedge spi_clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        staging_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      if (word_wr) begin
        staging_q[word_idx_q] <= asm_next;
      end
      if (commit) begin
        for (int unsigned i = 0; i < NUM_WORDS - 1; i++) begin
          active_q[i] <= staging_q[i];
        end
        active_q[NUM_WORDS-1] <= asm_next;
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (32'(rd_idx) < NUM_WORDS) begin
      rd_word = active_q[rd_idx];
    end
  end

  assign key_valid   = key_valid_q;
  assign load_done   = load_done_q;
  assign busy        = (state_q == StShift);
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_spi_key_loader.sv
// Directed bench for spi_key_loader: default 16x48 instance plus two 4x8 instances
// exercising both bit orders.
module tb_spi_key_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        cs_n, data;
  logic [3:0]  rd_idx;
  logic [47:0] rd_word;
  logic        key_valid, load_done, busy, frame_error;

  logic        cs_s, data_s;
  logic [1:0]  rd_idx_s;
  logic [7:0]  word_l, word_m;
  logic        kv_l, ld_l, bz_l, fe_l;
  logic        kv_m, ld_m, bz_m, fe_m;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int bad      = 0;

  spi_key_loader dut (
    .spi_clk     (clk),
    .n_reset     (n_reset),
    .spi_cs_n    (cs_n),
    .spi_data    (data),
    .rd_idx      (rd_idx),
    .rd_word     (rd_word),
    .key_valid   (key_valid),
    .load_done   (load_done),
    .busy        (busy),
    .frame_error (frame_error)
  );

  spi_key_loader #(.WORD_W(8), .NUM_WORDS(4), .LSB_FIRST(1)) dut_lsb (
    .spi_clk     (clk),
    .n_reset     (n_reset),
    .spi_cs_n    (cs_s),
    .spi_data    (data_s),
    .rd_idx      (rd_idx_s),
    .rd_word     (word_l),
    .key_valid   (kv_l),
    .load_done   (ld_l),
    .busy        (bz_l),
    .frame_error (fe_l)
  );

  spi_key_loader #(.WORD_W(8), .NUM_WORDS(4), .LSB_FIRST(0)) dut_msb (
    .spi_clk     (clk),
    .n_reset     (n_reset),
    .spi_cs_n    (cs_s),
    .spi_data    (data_s),
    .rd_idx      (rd_idx_s),
    .rd_word     (word_m),
    .key_valid   (kv_m),
    .load_done   (ld_m),
    .busy        (bz_m),
    .frame_error (fe_m)
  );

  always @(posedge clk) if (load_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit n of a default-geometry frame whose word k is base + k, MSB first.
  function automatic logic frame_bit(input logic [47:0] base, input int n);
    logic [47:0] w;
    w = base + 48'(n / 48);
    return w[47 - (n % 48)];
  endfunction

  task automatic send_stream(input logic [47:0] base, input int first, input int nbits,
                             input logic [47:0] old_word, input bit mon, output int nbad);
    nbad = 0;
    for (int n = first; n < first + nbits; n++) begin
      @(negedge clk);
      if (mon && (rd_word !== old_word || key_valid !== 1'b1)) nbad++;
      cs_n = 1'b0;
      data = frame_bit(base, n);
    end
  endtask

  initial begin
    n_reset  = 1'b0;
    cs_n     = 1'b1;
    data     = 1'b0;
    rd_idx   = '0;
    cs_s     = 1'b1;
    data_s   = 1'b0;
    rd_idx_s = '0;

    #12;
    check_eq("rst_key_valid", 64'(key_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_frame_error", 64'(frame_error), 64'd0);
    check_eq("rst_load_done", 64'(load_done), 64'd0);
    check_eq("rst_rd_word", 64'(rd_word), 64'd0);
    @(negedge clk) n_reset = 1'b1;

    // Frame 1: words 0123456789A0 + k
    send_stream(48'h0123_4567_89A0, 0, 767, 48'h0, 1'b0, bad);
    @(negedge clk);
    check_eq("f1_busy_mid", 64'(busy), 64'd1);
    check_eq("f1_no_early_done", 64'(load_done), 64'd0);
    data = frame_bit(48'h0123_4567_89A0, 767);
    @(negedge clk);
    check_eq("f1_load_done", 64'(load_done), 64'd1);
    check_eq("f1_key_valid", 64'(key_valid), 64'd1);
    check_eq("f1_busy", 64'(busy), 64'd0);
    check_eq("f1_frame_error", 64'(frame_error), 64'd0);
    rd_idx = 4'd0;
    #1 check_eq("f1_word0", 64'(rd_word), 64'h0123_4567_89A0);
    rd_idx = 4'd15;
    #1 check_eq("f1_word15", 64'(rd_word), 64'h0123_4567_89AF);
    cs_n = 1'b1;
    @(negedge clk);
    check_eq("f1_done_one_cycle", 64'(load_done), 64'd0);
    repeat (2) @(negedge clk);
    check_eq("f1_done_count", 64'(done_cnt), 64'd1);

    // Frame 2: reload while reading word 3 every cycle
    rd_idx = 4'd3;
    send_stream(48'hFFFF_0000_0000, 0, 768, 48'h0123_4567_89A3, 1'b1, bad);
    check_eq("f2_old_key_during_reload", 64'(bad), 64'd0);
    @(negedge clk);
    #1 check_eq("f2_new_word3", 64'(rd_word), 64'hFFFF_0000_0003);
    check_eq("f2_key_valid", 64'(key_valid), 64'd1);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("f2_done_count", 64'(done_cnt), 64'd2);

    // Abort after 100 bits
    send_stream(48'h1111_2222_3333, 0, 100, 48'h0, 1'b0, bad);
    @(negedge clk) cs_n = 1'b1;
    @(negedge clk);
    check_eq("abort_frame_error", 64'(frame_error), 64'd1);
    check_eq("abort_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    check_eq("abort_no_done", 64'(done_cnt), 64'd2);
    check_eq("abort_key_kept", 64'(rd_word), 64'hFFFF_0000_0003);
    check_eq("abort_key_valid", 64'(key_valid), 64'd1);

    // Full frame plus two overrun bits
    send_stream(48'hA5A5_1234_0000, 0, 1, 48'h0, 1'b0, bad);
    @(negedge clk);
    check_eq("ovr_fe_cleared", 64'(frame_error), 64'd0);
    check_eq("ovr_busy", 64'(busy), 64'd1);
    data = frame_bit(48'hA5A5_1234_0000, 1);
    send_stream(48'hA5A5_1234_0000, 2, 766, 48'h0, 1'b0, bad);
    @(negedge clk);
    check_eq("ovr_commit", 64'(load_done), 64'd1);
    check_eq("ovr_fe_before_extra", 64'(frame_error), 64'd0);
    data = 1'b1;
    @(negedge clk);
    check_eq("ovr_frame_error", 64'(frame_error), 64'd1);
    check_eq("ovr_busy_done", 64'(busy), 64'd0);
    check_eq("ovr_done_pulse_end", 64'(load_done), 64'd0);
    data = 1'b1;
    @(negedge clk) cs_n = 1'b1;
    @(negedge clk);
    rd_idx = 4'd0;
    #1 check_eq("ovr_word0", 64'(rd_word), 64'hA5A5_1234_0000);
    rd_idx = 4'd15;
    #1 check_eq("ovr_word15", 64'(rd_word), 64'hA5A5_1234_000F);
    check_eq("ovr_fe_holds", 64'(frame_error), 64'd1);
    check_eq("ovr_done_count", 64'(done_cnt), 64'd3);

    // Small instances: 1,0,0,0,0,0,0,0 x4
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 8; b++) begin
        @(negedge clk);
        cs_s   = 1'b0;
        data_s = (b == 0);
      end
    end
    @(negedge clk) cs_s = 1'b1;
    @(negedge clk);
    check_eq("small_lsb_valid", 64'(kv_l), 64'd1);
    check_eq("small_msb_valid", 64'(kv_m), 64'd1);
    for (int i = 0; i < 4; i++) begin
      rd_idx_s = 2'(i);
      #1;
      check_eq($sformatf("small_lsb_w%0d", i), 64'(word_l), 64'h01);
      check_eq($sformatf("small_msb_w%0d", i), 64'(word_m), 64'h80);
    end

    // Asynchronous reset in the middle of a frame
    rd_idx = 4'd3;
    send_stream(48'h7777_8888_9999, 0, 400, 48'h0, 1'b0, bad);
    #2 n_reset = 1'b0;
    #1;
    check_eq("arst_key_valid", 64'(key_valid), 64'd0);
    check_eq("arst_rd_word", 64'(rd_word), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_frame_error", 64'(frame_error), 64'd0);
    check_eq("arst_load_done", 64'(load_done), 64'd0);
    check_eq("arst_small_valid", 64'(kv_l), 64'd0);
    cs_n = 1'b1;
    @(negedge clk) n_reset = 1'b1;

    // Full frame after reset
    send_stream(48'h5A5A_0F0F_0100, 0, 768, 48'h0, 1'b0, bad);
    @(negedge clk);
    check_eq("post_rst_done", 64'(load_done), 64'd1);
    cs_n = 1'b1;
    rd_idx = 4'd0;
    #1 check_eq("post_rst_word0", 64'(rd_word), 64'h5A5A_0F0F_0100);
    rd_idx = 4'd7;
    #1 check_eq("post_rst_word7", 64'(rd_word), 64'h5A5A_0F0F_0107);
    rd_idx = 4'd15;
    #1 check_eq("post_rst_word15", 64'(rd_word), 64'h5A5A_0F0F_010F);
    check_eq("post_rst_key_valid", 64'(key_valid), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
